protocol_rsp_fsm: RTL
=====================

# protocol_rsp_fsm

Responder end of the single-wire protocol driven by `protocol_fsm`. The block watches the serial line, detects a start bit and shifts in a fixed-width data word. It then checks even parity and the stop bit. It presents the word with a one-cycle valid pulse and returns a one-cycle ack to the initiator, or raises an error pulse and resynchronises.

## Interface
- `DATA_W`, default 8: payload bits per frame, ≥2.
- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  asynchronous active-low reset.
- `in`  in  1  serial line from initiator; idles low.
- `data`  out  DATA_W  last correctly received word.
- `data_valid`  out  1  one-cycle pulse: `data` updated.
- `ack`  out  1  one-cycle pulse back to initiator: frame accepted.
- `err`  out  1  one-cycle pulse: parity or stop error.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- Frame, one bit per clock: start (1), DATA_W data bits LSB first, one even-parity bit, stop (0).
- Even parity: XOR of data bits and parity bit must be 0.
- States:
  - IDLE: `in`=1 → DATA, bit counter cleared.
  - DATA: shift `in` into the shift register at index = counter. Counter reaches DATA_W-1 → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: if parity ok and `in`=0, load `data` and pulse `data_valid` and `ack` → IDLE.
  - STOP, parity bad and `in`=0: pulse `err` → IDLE.
  - STOP, `in`=1 (framing error, with or without bad parity): pulse `err` → ERR.
  - ERR: wait for `in`=0 → IDLE. A high line in ERR is never taken as a start.
- Bit counter width is `$clog2(DATA_W)`. It never wraps past DATA_W-1.
- `data` holds its previous value on any errored frame.
- `data_valid` and `ack` are always coincident. `err` is mutually exclusive with both.
- Back-to-back frames: a start bit on the edge immediately after a good stop is accepted. There is no idle gap requirement.

## Timing
- All outputs are registered. Reset values: `data`=0, `data_valid`=0, `ack`=0, `err`=0, `busy`=0, state IDLE, counter 0.
- Start bit sampled on edge k. Data bits are sampled on edges k+1..k+DATA_W, parity on k+DATA_W+1, stop on k+DATA_W+2.
- `data_valid`/`ack`/`err` are high for exactly the cycle following edge k+DATA_W+2.
- `busy` rises after edge k. It falls after edge k+DATA_W+2, or after the edge that samples `in`=0 in ERR.
- `rstn` asserted mid-frame: all outputs and state return to reset values immediately, without waiting for a clock. The partial word is discarded. The first sampled edge after deassertion is treated as IDLE.

## Structure
- Shared package `protocol_pkg`:
  - state enum typedef `rsp_state_t` (IDLE, DATA, PARITY, STOP, ERR);
  - line-level constants `LINE_IDLE`=0, `START_BIT`=1, `STOP_BIT`=0, shared with `protocol_fsm`.
- Single module; shift register, counter and parity accumulator are inline. No sub-module.

## Test plan
- Reset: hold `rstn`=0 for 2 cycles with `in` toggling → all outputs 0 and `busy`=0 throughout.
- Good frame, DATA_W=8, 0xA5: line 1, bits 1,0,1,0,0,1,0,1, parity 0, stop 0 → `data`=0xA5, with `data_valid`=`ack`=1 for one cycle, 11 cycles after the start edge.
- Parity error: 0xA5 sent with parity 1 → `err` pulse, no `ack`. `data` stays 0xA5 from the prior frame.
- Stop error then recovery: stop=1 and `in` held high 3 more cycles → `err` pulse and `busy` held high, no new frame. Drop `in` low, then send 0x3C with parity 0 → `data`=0x3C and `ack`.
- Back-to-back: 0x01 (parity 1) then 0xFF (parity 0) with start immediately after stop → two `ack` pulses 11 cycles apart; `data` ends at 0xFF.
- Reset mid-frame: assert `rstn` after 4 data bits → `busy`=0 at once. After release, a full 0x5A frame receives correctly.

Source files
------------

// File: rtl/protocol_pkg.sv
// Shared definitions for both ends of the single-wire protocol: responder
// state encoding and the line levels that both sides agree on.
package protocol_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    ERR
  } rsp_state_t;

  localparam logic LINE_IDLE = 1'b0;
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/protocol_rsp_fsm.sv
// Responder for the single-wire protocol: detects a start bit, shifts in
// DATA_W bits LSB first, checks even parity and the stop bit, then either
// presents the word with a valid/ack pulse or pulses err and resynchronises.
module protocol_rsp_fsm
  import protocol_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

  rsp_state_t        state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic              par, par_d;       // running XOR of data bits
  logic              par_ok, par_ok_d; // result of the parity check
  logic [DATA_W-1:0] data_d;
  logic              valid_d, ack_d, err_d, busy_d;

  // Next-state, datapath and registered-output values for the coming edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would infer a latch.
    state_d  = state;
    cnt_d    = cnt;
    shreg_d  = shreg;
    par_d    = par;
    par_ok_d = par_ok;
    data_d   = data;
    valid_d  = 1'b0;
    ack_d    = 1'b0;
    err_d    = 1'b0;

    unique case (state)
      IDLE: begin
        if (in == START_BIT) begin
          state_d = DATA;
          cnt_d   = '0;
          par_d   = 1'b0;
        end
      end
      DATA: begin
        shreg_d[cnt] = in;
        par_d        = par ^ in;
        // The counter parks at the last index rather than wrapping.
        if (cnt == CNT_LAST) state_d = PARITY;
        else                 cnt_d   = cnt + CW'(1);
      end
      PARITY: begin
        par_ok_d = ~(par ^ in);
        state_d  = STOP;
      end
      STOP: begin
        if (in == STOP_BIT) begin
          state_d = IDLE;
          if (par_ok) begin
            data_d  = shreg;
            valid_d = 1'b1;
            ack_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          // Framing error: the line is still high, so it cannot be trusted
          // as a start bit until it has returned low.
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      ERR: begin
        if (in == LINE_IDLE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      par_ok     <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      ack        <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state      <= state_d;
      cnt        <= cnt_d;
      shreg      <= shreg_d;
      par        <= par_d;
      par_ok     <= par_ok_d;
      data       <= data_d;
      data_valid <= valid_d;
      ack        <= ack_d;
      err        <= err_d;
      busy       <= busy_d;
    end
  end

endmodule
